fir_decim_tdm: RTL and testbench

- Time-multiplexed, parametrised polyphase decimating FIR.
- Next generation of the dual-channel, 8-lane, decimate-by-8 filter. Generalised in channel count, decimation, tap count and MAC parallelism.
- Adds behaviour the previous generation lacks: runtime coefficient load, output backpressure (m_tready), channel tagging, and rounding/saturation to a configurable output width.
- Sits between the ADC lane packer and the downstream channelizer.

---
 rtl/fir_decim_tdm.sv | 196 +++++++++++++++++++
 tb/tb_fir_decim_tdm.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_tdm.sv
// Time-multiplexed polyphase decimating FIR: one bank of MACS multipliers walks each
// channel's delay line in N = TAP_COUNT/MACS cycles, then presents one rounded output.
module fir_decim_tdm #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAP_COUNT  = 120,
  parameter int DECIM      = 8,
  parameter int MACS       = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int SAT_EN     = 1,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ADDR_W    = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_tvalid,
  output logic                                 s_tready,
  input  logic [CHANNELS*DECIM*DATA_WIDTH-1:0] s_tdata,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic [OUT_WIDTH-1:0]                 m_tdata,
  output logic [CH_W-1:0]                      m_tchan,
  output logic                                 m_tsat,
  input  logic                                 coef_we,
  input  logic [ADDR_W-1:0]                    coef_addr,
  input  logic [COEF_WIDTH-1:0]                coef_wdata
);

  localparam int N      = TAP_COUNT / MACS;
  localparam int CNT_W  = $clog2(N + 2);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + $clog2(TAP_COUNT);
  localparam int RND_W  = ACC_W + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [CNT_W-1:0] MAC_END  = CNT_W'(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N + 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);

  localparam logic signed [RND_W-1:0] RND_BIAS = (SHIFT > 0) ? (RND_W'(1) <<< RND_SH) : '0;
  localparam logic signed [RND_W-1:0] OUT_MAX  = (RND_W'(1) <<< (OUT_WIDTH - 1)) - RND_W'(1);
  localparam logic signed [RND_W-1:0] OUT_MIN  = -OUT_MAX - RND_W'(1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                       state_reg, state_next;
  logic [CNT_W-1:0]             cnt_reg;
  logic [CH_W-1:0]              ch_reg;
  logic signed [DATA_WIDTH-1:0] line_reg [CHANNELS][TAP_COUNT];
  logic signed [COEF_WIDTH-1:0] coef_reg [TAP_COUNT];
  logic [MACS*PROD_W-1:0]       prod_flat;
  logic signed [ACC_W-1:0]      group_sum;
  logic signed [ACC_W-1:0]      acc_reg;
  logic signed [RND_W-1:0]      rounded, shifted;
  logic [OUT_WIDTH-1:0]         fmt_data;
  logic                         fmt_sat;
  logic [OUT_WIDTH-1:0]         m_tdata_reg;
  logic [CH_W-1:0]              m_tchan_reg;
  logic                         m_tsat_reg;
  logic                         in_fire, out_fire, mac_issue, mac_accum;

  assign s_tready  = (state_reg == IDLE);
  assign m_tvalid  = (state_reg == OUT);
  assign in_fire   = s_tvalid && (state_reg == IDLE);
  assign out_fire  = m_tready && (state_reg == OUT);
  assign mac_issue = (state_reg == MAC) && (cnt_reg < MAC_END);
  assign mac_accum = (state_reg == MAC) && (cnt_reg != '0) && (cnt_reg <= MAC_END);

  assign m_tdata = m_tdata_reg;
  assign m_tchan = m_tchan_reg;
  assign m_tsat  = m_tsat_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_fire) state_next = MAC;
      MAC:     if (cnt_reg == LAST_CNT) state_next = OUT;
      OUT:     if (out_fire) state_next = (ch_reg == LAST_CH) ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  // cnt runs 0..N+1: N issue cycles plus the multiply and accumulate tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      ch_reg  <= '0;
    end else begin
      if (in_fire || out_fire)   cnt_reg <= '0;
      else if (state_reg == MAC) cnt_reg <= cnt_reg + CNT_W'(1);
      if (in_fire)                            ch_reg <= '0;
      else if (out_fire && ch_reg != LAST_CH) ch_reg <= ch_reg + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAP_COUNT; k++)
          line_reg[c][k] <= '0;
    end else if (in_fire) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = DECIM; k < TAP_COUNT; k++)
          line_reg[c][k] <= line_reg[c][k-DECIM];
        for (int l = 0; l < DECIM; l++)
          line_reg[c][DECIM-1-l] <= s_tdata[(c*DECIM + l)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Writes are only honoured while idle, so a beat always sees one consistent set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAP_COUNT; k++)
        coef_reg[k] <= '0;
    end else if (coef_we && state_reg == IDLE && int'(coef_addr) < TAP_COUNT) begin
      coef_reg[coef_addr] <= coef_wdata;
    end
  end

  for (genvar gi = 0; gi < MACS; gi++) begin : g_mac
    logic signed [DATA_WIDTH-1:0] x_sel;
    logic signed [COEF_WIDTH-1:0] h_sel;
    logic signed [PROD_W-1:0]     prod_reg;

    always_comb begin
      x_sel = '0;
      h_sel = '0;
      for (int g = 0; g < N; g++) begin
        if (int'(cnt_reg) == g) begin
          h_sel = coef_reg[g*MACS + gi];
          for (int c = 0; c < CHANNELS; c++)
            if (int'(ch_reg) == c) x_sel = line_reg[c][g*MACS + gi];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst)            prod_reg <= '0;
      else if (mac_issue) prod_reg <= x_sel * h_sel;
    end

    assign prod_flat[gi*PROD_W +: PROD_W] = prod_reg;
  end

  always_comb begin
    group_sum = '0;
    for (int m = 0; m < MACS; m++)
      group_sum = group_sum + ACC_W'($signed(prod_flat[m*PROD_W +: PROD_W]));
  end

  always_ff @(posedge clk) begin
    if (rst)                     acc_reg <= '0;
    else if (in_fire || out_fire) acc_reg <= '0;
    else if (mac_accum)          acc_reg <= acc_reg + group_sum;
  end

  // Round half up, then either clamp or keep only the low OUT_WIDTH bits.
  always_comb begin
    rounded  = RND_W'(acc_reg) + RND_BIAS;
    shifted  = rounded >>> SHIFT;
    fmt_data = shifted[OUT_WIDTH-1:0];
    fmt_sat  = 1'b0;
    if (SAT_EN != 0) begin
      if (shifted > OUT_MAX) begin
        fmt_data = OUT_MAX[OUT_WIDTH-1:0];
        fmt_sat  = 1'b1;
      end else if (shifted < OUT_MIN) begin
        fmt_data = OUT_MIN[OUT_WIDTH-1:0];
        fmt_sat  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata_reg <= '0;
      m_tchan_reg <= '0;
      m_tsat_reg  <= 1'b0;
    end else if (state_reg == MAC && cnt_reg == LAST_CNT) begin
      m_tdata_reg <= fmt_data;
      m_tchan_reg <= ch_reg;
      m_tsat_reg  <= fmt_sat;
    end else if (out_fire) begin
      m_tsat_reg  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decim_tdm.sv
// Scoreboard bench for fir_decim_tdm: a saturating and a wrapping instance run in lockstep
// against a reference FIR model; scenario tasks add constant checks from the test plan.
module tb_fir_decim_tdm;

  localparam int CH     = 2;
  localparam int DW     = 16;
  localparam int TAPS   = 120;
  localparam int DEC    = 8;
  localparam int BEAT_W = CH*DEC*DW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_tvalid = 1'b0;
  logic              m_tready = 1'b0;
  logic              coef_we = 1'b0;
  logic [BEAT_W-1:0] s_tdata = '0;
  logic [6:0]        coef_addr = '0;
  logic [15:0]       coef_wdata = '0;

  logic        s_tready, m_tvalid, m_tsat;
  logic [15:0] m_tdata;
  logic [0:0]  m_tchan;
  logic        w_s_tready, w_m_tvalid, w_m_tsat;
  logic [15:0] w_m_tdata;
  logic [0:0]  w_m_tchan;

  fir_decim_tdm dut (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tchan(m_tchan),
    .m_tsat(m_tsat), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
  );

  fir_decim_tdm #(.SAT_EN(0)) dut_wrap (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(w_s_tready), .s_tdata(s_tdata),
    .m_tvalid(w_m_tvalid), .m_tready(m_tready), .m_tdata(w_m_tdata), .m_tchan(w_m_tchan),
    .m_tsat(w_m_tsat), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint sum; int chan; } exp_t;
  typedef struct { logic [15:0] data; int chan; logic sat; logic [15:0] wdata; logic wsat; } got_t;

  exp_t exp_q[$];
  got_t got_q[$];
  int   checks = 0, errors = 0, out_count = 0, accept_cyc = 0;

  logic signed [15:0] mh [TAPS];
  logic signed [15:0] mx [CH][TAPS];

  // Reference: shift the model lines, then queue one expected full-precision sum per channel.
  task automatic model_accept(input logic [BEAT_W-1:0] d);
    longint sum;
    for (int c = 0; c < CH; c++) begin
      for (int k = TAPS-1; k >= DEC; k--) mx[c][k] = mx[c][k-DEC];
      for (int l = 0; l < DEC; l++) mx[c][DEC-1-l] = d[(c*DEC + l)*DW +: DW];
    end
    for (int c = 0; c < CH; c++) begin
      sum = 0;
      for (int k = 0; k < TAPS; k++) sum += longint'(mh[k]) * longint'(mx[c][k]);
      exp_q.push_back('{sum: sum, chan: c});
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      mh[k] = '0;
      for (int c = 0; c < CH; c++) mx[c][k] = '0;
    end
    exp_q.delete();
  endtask

  exp_t        e;
  got_t        g;
  longint      r;
  logic [15:0] ed;
  logic        es;

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      out_count++;
      g.data = m_tdata; g.chan = int'(m_tchan); g.sat = m_tsat;
      g.wdata = w_m_tdata; g.wsat = w_m_tsat;
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got data %0d chan %0d, required no output", $signed(m_tdata), m_tchan);
      end else begin
        e = exp_q.pop_front();
        r = (e.sum + 64'sd16384) >>> 15;
        if (r > 32767)       begin ed = 16'h7FFF; es = 1'b1; end
        else if (r < -32768) begin ed = 16'h8000; es = 1'b1; end
        else                 begin ed = r[15:0];  es = 1'b0; end
        checks += 6;
        if (m_tdata !== ed) begin errors++;
          $display("FAIL sb_data: got %0d required %0d", $signed(m_tdata), $signed(ed)); end
        if (int'(m_tchan) != e.chan) begin errors++;
          $display("FAIL sb_chan: got %0d required %0d", m_tchan, e.chan); end
        if (m_tsat !== es) begin errors++;
          $display("FAIL sb_sat: got %0b required %0b", m_tsat, es); end
        if (w_m_tvalid !== 1'b1) begin errors++;
          $display("FAIL sb_wrap_valid: got %0b required 1", w_m_tvalid); end
        if (w_m_tdata !== r[15:0]) begin errors++;
          $display("FAIL sb_wrap_data: got %0d required %0d", $signed(w_m_tdata), $signed(r[15:0])); end
        if (w_m_tsat !== 1'b0) begin errors++;
          $display("FAIL sb_wrap_sat: got %0b required 0", w_m_tsat); end
        $display("out chan %0d data %0d sat %0b wrap %0d expected_sum %0d", m_tchan, $signed(m_tdata), m_tsat, $signed(w_m_tdata), e.sum);
      end
    end
  end

  task automatic write_coef(input int addr, input logic [15:0] val, input bit upd);
    coef_addr = 7'(addr); coef_wdata = val; coef_we = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (upd) mh[addr] = val;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(exp_q.size() == 0 && s_tready) && n < 3000);
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout: got %0d pending outputs, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [BEAT_W-1:0] d, input bit we, input int addr, input logic [15:0] wdata);
    int n = 0;
    s_tdata = d; s_tvalid = 1'b1;
    if (we) begin coef_addr = 7'(addr); coef_wdata = wdata; coef_we = 1'b1; end
    do begin
      @(negedge clk); n++;
    end while (!s_tready && n < 3000);
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got s_tready 0, required 1");
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; coef_we = 1'b0;
    accept_cyc = cyc;
    if (we) mh[addr] = wdata;
    model_accept(d);
    $display("beat accepted at cycle %0d", accept_cyc);
  endtask

  function automatic logic [BEAT_W-1:0] fill_beat(input logic [15:0] v);
    logic [BEAT_W-1:0] d;
    for (int i = 0; i < CH*DEC; i++) d[i*DW +: DW] = v;
    return d;
  endfunction

  function automatic logic [BEAT_W-1:0] impulse_beat();
    logic [BEAT_W-1:0] d = '0;
    d[7*DW +: DW] = 16'h7FFF;
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready: got %0b required 1", s_tready); end
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %0b required 0", m_tvalid); end
    if (m_tdata !== 16'h0) begin errors++; $display("FAIL reset_m_tdata: got %0h required 0", m_tdata); end
    if (m_tchan !== 1'b0)  begin errors++; $display("FAIL reset_m_tchan: got %0b required 0", m_tchan); end
    if (m_tsat !== 1'b0)   begin errors++; $display("FAIL reset_m_tsat: got %0b required 0", m_tsat); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    $display("reset checked");
  endtask

  task automatic test_impulse();
    logic [15:0] req_d [4] = '{16'd16384, 16'd0, 16'd8192, 16'd0};
    int n = 0;
    m_tready = 1'b1;
    write_coef(0, 16'h4000, 1'b1);
    write_coef(8, 16'h2000, 1'b1);
    got_q.delete();
    send_beat(impulse_beat(), 1'b0, 0, 16'h0);
    do begin @(negedge clk); n++; end while (!m_tvalid && n < 100);
    checks++;
    if (cyc - accept_cyc != 17) begin errors++;
      $display("FAIL impulse_latency: got %0d cycles required 17", cyc - accept_cyc); end
    send_beat('0, 1'b0, 0, 16'h0);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q.size() <= i) begin errors++;
        $display("FAIL impulse_count: got %0d outputs required 4", got_q.size()); end
      else if (got_q[i].data !== req_d[i] || got_q[i].chan != (i % 2)) begin errors++;
        $display("FAIL impulse_out%0d: got data %0d chan %0d required data %0d chan %0d",
                 i, $signed(got_q[i].data), got_q[i].chan, req_d[i], i % 2); end
    end
  endtask

  task automatic test_backpressure();
    logic [BEAT_W-1:0] d1, d2;
    logic [15:0] hd; logic hc, hs;
    int base, n = 0;
    for (int i = 0; i < CH*DEC; i++) begin
      d1[i*DW +: DW] = 16'($urandom);
      d2[i*DW +: DW] = 16'($urandom);
    end
    wait_idle();
    m_tready = 1'b0;
    base = out_count;
    send_beat(d1, 1'b0, 0, 16'h0);
    do begin @(negedge clk); n++; end while (!m_tvalid && n < 100);
    hd = m_tdata; hc = m_tchan; hs = m_tsat;
    s_tdata = d2; s_tvalid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checks += 3;
      if (m_tvalid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %0b required 1", m_tvalid); end
      if ({m_tdata, m_tchan, m_tsat} !== {hd, hc, hs}) begin errors++;
        $display("FAIL stall_stable: got %0h/%0b/%0b required %0h/%0b/%0b", m_tdata, m_tchan, m_tsat, hd, hc, hs); end
      if (s_tready !== 1'b0) begin errors++; $display("FAIL stall_s_tready: got %0b required 0", s_tready); end
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    send_beat(d2, 1'b0, 0, 16'h0);
    checks++;
    if (out_count - base != 2) begin errors++;
      $display("FAIL stall_accept_order: got %0d outputs before accept required 2", out_count - base); end
    wait_idle();
  endtask

  task automatic test_coef_gating();
    send_beat('0, 1'b0, 0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    write_coef(0, 16'h7FFF, 1'b0);
    wait_idle();
    got_q.delete();
    send_beat(impulse_beat(), 1'b0, 0, 16'h0);
    wait_idle();
    checks++;
    if (got_q.size() < 1 || got_q[0].data !== 16'd16384) begin errors++;
      $display("FAIL gate_mac_write: got %0d required 16384", (got_q.size() > 0) ? $signed(got_q[0].data) : -1); end
    send_beat('0, 1'b0, 0, 16'h0);
    wait_idle();
    got_q.delete();
    send_beat(impulse_beat(), 1'b1, 0, 16'h7FFF);
    wait_idle();
    checks++;
    if (got_q.size() < 1 || got_q[0].data !== 16'd32766) begin errors++;
      $display("FAIL gate_idle_write: got %0d required 32766", (got_q.size() > 0) ? $signed(got_q[0].data) : -1); end
  endtask

  task automatic test_step();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'h7FFF, 1'b1);
    got_q.delete();
    for (int b = 0; b < 15; b++) send_beat(fill_beat(16'h7FFF), 1'b0, 0, 16'h0);
    wait_idle();
    checks += 2;
    if (got_q.size() == 0 || got_q[$].data !== 16'h7FFF || got_q[$].sat !== 1'b1) begin errors++;
      $display("FAIL step_pos_sat: got last %0h sat %0b required 7fff sat 1",
               (got_q.size() > 0) ? got_q[$].data : 16'hx, (got_q.size() > 0) ? got_q[$].sat : 1'bx); end
    if (got_q.size() == 0 || got_q[$].wdata !== 16'hFF10 || got_q[$].wsat !== 1'b0) begin errors++;
      $display("FAIL step_pos_wrap: got last %0h required ff10", (got_q.size() > 0) ? got_q[$].wdata : 16'hx); end
    got_q.delete();
    for (int b = 0; b < 15; b++) send_beat(fill_beat(16'h8000), 1'b0, 0, 16'h0);
    wait_idle();
    checks += 2;
    if (got_q.size() == 0 || got_q[$].data !== 16'h8000 || got_q[$].sat !== 1'b1) begin errors++;
      $display("FAIL step_neg_sat: got last %0h required 8000 sat 1", (got_q.size() > 0) ? got_q[$].data : 16'hx); end
    if (got_q.size() == 0 || got_q[$].wdata !== 16'h0078 || got_q[$].wsat !== 1'b0) begin errors++;
      $display("FAIL step_neg_wrap: got last %0h required 0078", (got_q.size() > 0) ? got_q[$].wdata : 16'hx); end
  endtask

  task automatic test_mid_reset();
    int base, n = 0;
    for (int k = 0; k < TAPS; k++) write_coef(k, (k == 0) ? 16'h4000 : 16'h0, 1'b1);
    base = out_count;
    send_beat(impulse_beat(), 1'b0, 0, 16'h0);
    do begin @(negedge clk); n++; end while (out_count == base && n < 100);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    checks += 2;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_m_tvalid: got %0b required 0", m_tvalid); end
    if (s_tready !== 1'b1) begin errors++; $display("FAIL midrst_s_tready: got %0b required 1", s_tready); end
    @(posedge clk); #1;
    got_q.delete();
    send_beat(impulse_beat(), 1'b0, 0, 16'h0);
    wait_idle();
    checks++;
    if (got_q.size() != 2 || got_q[0].data !== 16'h0 || got_q[1].data !== 16'h0) begin errors++;
      $display("FAIL midrst_impulse: got %0d outputs first %0h required 2 zeros",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 16'hx); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_backpressure();
    test_coef_gating();
    test_step();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin errors++;
      $display("FAIL sb_leftover: got %0d pending required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
